// File: rtl/elixirchip_es1_spu_chk_pkg.sv
// elixirchip_es1_spu_chk_pkg: shared constants and saturating increment for SPU checkers
package elixirchip_es1_spu_chk_pkg;
  localparam int DEFAULT_COUNT_BITS = 32;
  virtual class sat_inc #(parameter int W = DEFAULT_COUNT_BITS);
    static function logic [W-1:0] calc(input logic [W-1:0] v);
      return &v ? v : v + 1'b1;
    endfunction
  endclass
endpackage

// File: rtl/elixirchip_es1_spu_chk_delay.sv
// elixirchip_es1_spu_chk_delay: cke-gated resettable delay line, depth 0 is a pass-through
module elixirchip_es1_spu_chk_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             cke,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] m_data
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{reset, clk, cke};
    assign m_data = s_data;
  end else begin : g_line
    logic [WIDTH-1:0] stg [DEPTH];
    always_ff @(posedge clk) begin
      if (reset) begin
        stg <= '{default: '0};
      end else if (cke) begin
        stg[0] <= s_data;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end
    assign m_data = stg[DEPTH-1];
  end
endmodule

// File: rtl/elixirchip_es1_spu_chk_srl.sv
// elixirchip_es1_spu_chk_srl: reference-pipeline checker for the logical right-shift SPU op
module elixirchip_es1_spu_chk_srl
  import elixirchip_es1_spu_chk_pkg::*;
#(
  parameter int  LATENCY    = 1,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter int  MAX_SHIFT  = DATA_BITS,
  parameter int  SHIFT_BITS = $clog2(MAX_SHIFT) + 1,
  parameter type shift_t    = logic [SHIFT_BITS-1:0],
  parameter data_t CLEAR_DATA = '1,
  parameter int  COUNT_BITS = DEFAULT_COUNT_BITS
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  shift_t                s_shift,
  input  data_t                 s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  input  data_t                 m_data,
  output logic                  armed,
  output logic                  err_flag,
  output logic [COUNT_BITS-1:0] err_count,
  output logic [COUNT_BITS-1:0] chk_count,
  output logic [COUNT_BITS-1:0] first_err_index,
  output data_t                 first_err_exp,
  output data_t                 first_err_act
);
  data_t                res;
  logic [DATA_BITS+1:0] fin;
  logic                 fin_clear;
  logic                 fin_valid;
  logic                 armed_next;
  logic                 chk_en;
  data_t                exp_data;
  always_comb begin
    res        = int'(s_shift) >= DATA_BITS ? '0 : s_data >> s_shift;
    fin_clear  = fin[DATA_BITS+1];
    fin_valid  = fin[DATA_BITS];
    armed_next = armed | (cke & (fin_clear | fin_valid));
  end
  elixirchip_es1_spu_chk_delay #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(LATENCY - 1)
  ) u_delay (
    .reset (reset),
    .clk   (clk),
    .cke   (cke),
    .s_data({s_clear, s_valid, res}),
    .m_data(fin)
  );
  // compare lags the exp update by one edge so a stalled output is checked once
  always_ff @(posedge clk) begin
    if (reset) begin
      armed           <= 1'b0;
      chk_en          <= 1'b0;
      exp_data        <= CLEAR_DATA;
      err_flag        <= 1'b0;
      err_count       <= '0;
      chk_count       <= '0;
      first_err_index <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else begin
      armed  <= armed_next;
      chk_en <= cke & armed_next;
      if (cke && fin_clear) exp_data <= CLEAR_DATA;
      else if (cke && fin_valid) exp_data <= data_t'(fin[DATA_BITS-1:0]);
      if (chk_en) begin
        chk_count <= sat_inc#(COUNT_BITS)::calc(chk_count);
        if (m_data != exp_data) begin
          err_count <= sat_inc#(COUNT_BITS)::calc(err_count);
          err_flag  <= 1'b1;
          if (!err_flag) begin
            first_err_index <= chk_count;
            first_err_exp   <= exp_data;
            first_err_act   <= m_data;
          end
        end
      end
    end
  end
endmodule
